// File: rtl/clk_gen_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clk_gen_pkg;

   localparam int CNT_W_DEF         = 6;
   localparam int DEFAULT_RATIO_DEF = 5;

   function automatic int ch_width(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

   // A zero half-period is meaningless; treat it as the fastest legal ratio.
   function automatic int unsigned clamp_ratio(input int unsigned ratio);
      return (ratio == 0) ? 1 : ratio;
   endfunction

endpackage

// File: rtl/clk_gen_multi_if.sv
// Config and output bundle of clk_gen_multi; ch_en exists only with CLK_GEN_MULTI_GATE_EN.
interface clk_gen_multi_if
   import clk_gen_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = CNT_W_DEF,
   parameter int CH_W   = ch_width(NUM_CH)
);
   logic              cfg_valid;
   logic              cfg_ready;
   logic [CH_W-1:0]   cfg_ch;
   logic [CNT_W-1:0]  cfg_ratio;
   logic              align;
   logic              clock_2x;
   logic [NUM_CH-1:0] clock_div;
   logic [NUM_CH-1:0] div_tick;
`ifdef CLK_GEN_MULTI_GATE_EN
   logic [NUM_CH-1:0] ch_en;

   modport master (output cfg_valid, cfg_ch, cfg_ratio, align, ch_en,
                   input  cfg_ready, clock_2x, clock_div, div_tick);
   modport slave  (input  cfg_valid, cfg_ch, cfg_ratio, align, ch_en,
                   output cfg_ready, clock_2x, clock_div, div_tick);
`else
   modport master (output cfg_valid, cfg_ch, cfg_ratio, align,
                   input  cfg_ready, clock_2x, clock_div, div_tick);
   modport slave  (input  cfg_valid, cfg_ch, cfg_ratio, align,
                   output cfg_ready, clock_2x, clock_div, div_tick);
`endif
endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: wrap counter, active/pending ratio, toggle + tick, align and gating.
module clk_div_ch
   import clk_gen_pkg::*;
#(
   parameter int CNT_W         = CNT_W_DEF,
   parameter int DEFAULT_RATIO = DEFAULT_RATIO_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_align,
   input  logic             i_cfg_we,
   input  logic [CNT_W-1:0] i_cfg_ratio,
   output logic             o_pending,
   output logic             o_div,
   output logic             o_tick
);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] r_ratio_active;
   logic [CNT_W-1:0] r_ratio_pending;
   logic             r_pending;
   logic             r_div;
   logic             r_tick;
   logic [CNT_W-1:0] w_cfg_ratio;
   logic             w_wrap;
   logic             w_run;

   assign w_cfg_ratio = CNT_W'(clamp_ratio(32'(i_cfg_ratio)));
   assign w_wrap      = (r_count == (r_ratio_active - ONE));
   // A disabled channel keeps running while high so it always ends on a clean falling edge.
   assign w_run       = i_en | r_div;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_count         <= '0;
         r_ratio_active  <= CNT_W'(DEFAULT_RATIO);
         r_ratio_pending <= '0;
         r_pending       <= 1'b0;
         r_div           <= 1'b0;
         r_tick          <= 1'b0;
      end else if (i_align) begin
         r_count   <= '0;
         r_div     <= 1'b0;
         r_tick    <= 1'b0;
         r_pending <= 1'b0;
         if (i_cfg_we)
            r_ratio_active <= w_cfg_ratio;
         else if (r_pending)
            r_ratio_active <= r_ratio_pending;
      end else begin
         if (!w_run) begin
            r_count <= '0;
            r_tick  <= 1'b0;
            if (r_pending) begin
               r_ratio_active <= r_ratio_pending;
               r_pending      <= 1'b0;
            end
         end else if (w_wrap) begin
            r_count <= '0;
            r_div   <= ~r_div;
            r_tick  <= 1'b1;
            if (r_pending) begin
               r_ratio_active <= r_ratio_pending;
               r_pending      <= 1'b0;
            end
         end else begin
            r_count <= r_count + ONE;
            r_tick  <= 1'b0;
         end
         // Accept only happens with pending clear, so it never races the wrap update above.
         if (i_cfg_we) begin
            r_ratio_pending <= w_cfg_ratio;
            r_pending       <= 1'b1;
         end
      end
   end

   assign o_pending = r_pending;
   assign o_div     = r_div;
   assign o_tick    = r_tick;

endmodule

// File: rtl/clk_gen_multi.sv
// Multi-channel programmable clock divider top: clock_2x, config decode, channel array.
// Define CLK_GEN_MULTI_GATE_EN to add per-channel ch_en gating.
module clk_gen_multi
   import clk_gen_pkg::*;
#(
   parameter int NUM_CH        = 2,
   parameter int CNT_W         = CNT_W_DEF,
   parameter int DEFAULT_RATIO = DEFAULT_RATIO_DEF
) (
   input  logic           original_clock,
   input  logic           reset_in,
   clk_gen_multi_if.slave bus
);
   localparam int CH_W = ch_width(NUM_CH);

   logic              r_clock_2x;
   logic [NUM_CH-1:0] w_pending;
   logic [NUM_CH-1:0] w_cfg_we;
   logic [NUM_CH-1:0] w_en;
   logic [NUM_CH-1:0] w_div;
   logic [NUM_CH-1:0] w_tick;
   logic              w_cfg_ready;

   always_ff @(posedge original_clock or posedge reset_in) begin
      if (reset_in)
         r_clock_2x <= 1'b1;
      else if (bus.align)
         r_clock_2x <= 1'b1;
      else
         r_clock_2x <= ~r_clock_2x;
   end

   // Out-of-range channel indices match nothing, so they stay ready and are dropped.
   always_comb begin
      w_cfg_ready = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
         if (bus.cfg_ch == CH_W'(i))
            w_cfg_ready = ~w_pending[i];
      end
   end

`ifdef CLK_GEN_MULTI_GATE_EN
   assign w_en = bus.ch_en;
`else
   assign w_en = '1;
`endif

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign w_cfg_we[g] = bus.cfg_valid & (bus.cfg_ch == CH_W'(g)) & ~w_pending[g];

      clk_div_ch #(
         .CNT_W         (CNT_W),
         .DEFAULT_RATIO (DEFAULT_RATIO)
      ) u_ch (
         .i_clk       (original_clock),
         .i_rst       (reset_in),
         .i_en        (w_en[g]),
         .i_align     (bus.align),
         .i_cfg_we    (w_cfg_we[g]),
         .i_cfg_ratio (bus.cfg_ratio),
         .o_pending   (w_pending[g]),
         .o_div       (w_div[g]),
         .o_tick      (w_tick[g])
      );
   end

   assign bus.cfg_ready = w_cfg_ready;
   assign bus.clock_2x  = r_clock_2x;
   assign bus.clock_div = w_div;
   assign bus.div_tick  = w_tick;

endmodule
